adc_timing_generator: RTL and testbench
=======================================

ADC_TIMING_GENERATOR -- requirements
Module: adc_timing_generator

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- PERIOD, 50, clock cycles per conversion frame (2 MS/s at 100 MHz).
- CNT_W, 6, frame counter width; PERIOD <= 2**CNT_W.
- CLK_LOW, 18, first count with clk_2mhz_utdc low.
- CLK_HIGH, 44, first count with clk_2mhz_utdc high again.
- WS_START, 34, first count with word_sync_n low.
- WS_END, 39, first count with word_sync_n high again.
- CONV_START, 44, first count with start_conv_n low; it stays low through PERIOD-1.
- SYNC_PHASE, 0, count loaded on an external sync edge.
- MISS_MAX, 4, consecutive frames without a sync edge before lock is lost.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- PLL_clk_100MHz, in, 1, the only clock.
- reset, in, 1, synchronous, active-high.
- sync_en, in, 1, 1 = align the frame to ext_sync; 0 = free-run.
- ext_sync, in, 1, ATCA 2 MHz common clock; asynchronous.
- clk_2mhz_utdc, out, 1, frame clock.
- ADCs_word_sync, out, 1, active-low word sync.
- ADCs_start_conv_out, out, 1, active-low conversion start.
- frame_tick, out, 1, one-cycle pulse when the counter wraps.
- locked, out, 1, high while in state LOCKED.
- slip_count, out, 8, count of realignments, saturating.
- frame_cnt, out, CNT_W, current counter value.
REQ-003 The clock SHALL be the single clock; reset is synchronous and active-high.

Function
REQ-004 The counter SHALL increment each cycle and wrap from PERIOD-1 to 0, in all states; a sync realignment overrides this.
REQ-005 Timing outputs SHALL be registered decodes of the counter, one cycle of latency:
- clk_2mhz_utdc = 0 for CLK_LOW <= cnt < CLK_HIGH, else 1.
- ADCs_word_sync = 0 for WS_START <= cnt < WS_END, else 1.
- ADCs_start_conv_out = 0 for cnt >= CONV_START, else 1.
REQ-006 frame_tick SHALL be 1 in the cycle after the counter holds PERIOD-1.
REQ-007 ext_sync SHALL pass through a two-flop synchroniser; a rising edge (sync_edge) is detected on the synchronised signal, giving 3 cycles of latency from pin to sync_edge.
REQ-008 The state machine SHALL have three states: FREE, SEEK and LOCKED.
REQ-009 FREE transitions: to SEEK when sync_en = 1; sync edges are ignored in FREE.
REQ-010 SEEK transitions: on sync_edge, load the counter with SYNC_PHASE in the next cycle and go to LOCKED; sync_en = 0 returns to FREE.
REQ-011 LOCKED, correct phase: a sync_edge while cnt = (SYNC_PHASE-1) mod PERIOD SHALL be an in-phase edge; the count advances normally and the miss counter clears.
REQ-012 LOCKED, wrong phase: any other sync_edge SHALL reload the counter to SYNC_PHASE, increment slip_count (saturating at 255), clear the miss counter, and stay in LOCKED.
REQ-013 LOCKED, missing edges: each wrap with no sync_edge since the previous wrap SHALL increment the miss counter; reaching MISS_MAX goes to SEEK with the counter still running.
REQ-014 LOCKED exit on disable: sync_en = 0 SHALL go to FREE.
REQ-015 Simultaneous events: if a sync_edge coincides with a wrap, realignment takes precedence and the wrap counts as a frame that had an edge.
REQ-016 A realignment SHALL never produce a glitch shorter than one cycle; outputs follow the decode of the reloaded count.

Reset
REQ-017 On reset SHALL set:
- counter = 0 and state = FREE.
- miss counter = 0 and slip_count = 0.
- clk_2mhz_utdc = 1, ADCs_word_sync = 1, ADCs_start_conv_out = 1.
- frame_tick = 0, locked = 0.
- synchroniser flops = 0.
REQ-018 Reset asserted mid-frame SHALL take effect on the next edge; decoding resumes from count 0 in the cycle after release.

Structure
REQ-019 A shared package SHALL hold the state encoding (FREE, SEEK, LOCKED) and the default timing constants.
REQ-020 The synchroniser and edge detector SHALL be a sub-module named sync_edge_detect; everything else stays flat.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Free-run with defaults, sync_en = 0: period 50; clk low for 26 cycles, word_sync low for 5 cycles, start_conv low for 6 cycles; frame_tick every 50 cycles; locked = 0.
- sync_en = 1, then an ext_sync edge at an arbitrary phase: locked = 1 and frame_cnt = 0 four cycles after the pin edge; slip_count = 0.
- Locked with a steady 2 MHz ext_sync: zero slips over 1000 frames.
- Locked, then ext_sync shifted by 7 cycles: one realignment and slip_count = 1; later edges are in phase.
- Locked, then ext_sync stopped: locked falls at the 4th wrap without an edge; outputs keep running.
- Reset pulse mid-frame at count 40: all outputs are 1 and frame_cnt = 0 the cycle after reset; slip_count = 0.

Source files
------------

// File: rtl/adc_timing_generator_pkg.sv
// Shared state encoding, default frame timing and the counter-to-timing decode
// used by the ADC timing generator.
package adc_timing_generator_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_FREE   = 2'd0;
    localparam state_t ST_SEEK   = 2'd1;
    localparam state_t ST_LOCKED = 2'd2;

    localparam int DEF_PERIOD     = 50;
    localparam int DEF_CNT_W      = 6;
    localparam int DEF_CLK_LOW    = 18;
    localparam int DEF_CLK_HIGH   = 44;
    localparam int DEF_WS_START   = 34;
    localparam int DEF_WS_END     = 39;
    localparam int DEF_CONV_START = 44;
    localparam int DEF_SYNC_PHASE = 0;
    localparam int DEF_MISS_MAX   = 4;
    localparam int SLIP_W         = 8;

    typedef struct packed {
        logic clk;
        logic ws_n;
        logic conv_n;
        logic tick;
    } timing_t;

    localparam timing_t TIM_IDLE = '{clk: 1'b1, ws_n: 1'b1, conv_n: 1'b1, tick: 1'b0};

    // Pure decode of one frame count into the four timing outputs.
    function automatic timing_t decode_timing(
        input int cnt,
        input int period,
        input int clk_low,
        input int clk_high,
        input int ws_start,
        input int ws_end,
        input int conv_start
    );
        timing_t t;
        t.clk    = !((cnt >= clk_low) && (cnt < clk_high));
        t.ws_n   = !((cnt >= ws_start) && (cnt < ws_end));
        t.conv_n = !(cnt >= conv_start);
        t.tick   = (cnt == period - 1);
        return t;
    endfunction

endpackage

// File: rtl/adc_timing_generator_sync_edge_detect.sv
// Two-flop synchroniser for the asynchronous ext_sync pin followed by a
// registered rising-edge detector; o_edge pulses 3 cycles after the pin rises.
module sync_edge_detect (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_edge
);

    logic r_meta;
    logic r_sync;
    logic r_sync_d;
    logic r_edge;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_sync_d <= 1'b0;
            r_edge   <= 1'b0;
        end else begin
            r_meta   <= i_async;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
            r_edge   <= r_sync & ~r_sync_d;
        end
    end

    assign o_edge = r_edge;

endmodule

// File: rtl/adc_timing_generator.sv
// Frame counter and timing decode for the ADC front end, optionally phase-locked
// to the external 2 MHz sync with slip counting and loss-of-lock detection.
module adc_timing_generator
    import adc_timing_generator_pkg::*;
#(
    parameter int PERIOD     = DEF_PERIOD,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int CLK_LOW    = DEF_CLK_LOW,
    parameter int CLK_HIGH   = DEF_CLK_HIGH,
    parameter int WS_START   = DEF_WS_START,
    parameter int WS_END     = DEF_WS_END,
    parameter int CONV_START = DEF_CONV_START,
    parameter int SYNC_PHASE = DEF_SYNC_PHASE,
    parameter int MISS_MAX   = DEF_MISS_MAX
) (
    input  logic              PLL_clk_100MHz,
    input  logic              reset,
    input  logic              sync_en,
    input  logic              ext_sync,
    output logic              clk_2mhz_utdc,
    output logic              ADCs_word_sync,
    output logic              ADCs_start_conv_out,
    output logic              frame_tick,
    output logic              locked,
    output logic [SLIP_W-1:0] slip_count,
    output logic [CNT_W-1:0]  frame_cnt
);

    localparam int MISS_W = $clog2(MISS_MAX + 1);

    localparam logic [CNT_W-1:0]  L_LAST       = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0]  L_SYNC_PHASE = CNT_W'(SYNC_PHASE);
    localparam logic [CNT_W-1:0]  L_SYNC_PREV  = CNT_W'((SYNC_PHASE + PERIOD - 1) % PERIOD);
    localparam logic [MISS_W-1:0] L_MISS_LAST  = MISS_W'(MISS_MAX - 1);

    function automatic logic [SLIP_W-1:0] sat_inc(input logic [SLIP_W-1:0] v);
        return (v == {SLIP_W{1'b1}}) ? v : v + SLIP_W'(1);
    endfunction

    logic              w_sync_edge;
    logic              w_wrap;
    logic [CNT_W-1:0]  w_cnt_inc;
    timing_t           w_tim;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [MISS_W-1:0] r_miss;
    logic [MISS_W-1:0] w_miss_nxt;
    logic              r_seen;
    logic              w_seen_nxt;
    logic [SLIP_W-1:0] r_slip;
    logic [SLIP_W-1:0] w_slip_nxt;
    timing_t           r_tim;

    sync_edge_detect u_sync_edge_detect (
        .i_clk   (PLL_clk_100MHz),
        .i_rst   (reset),
        .i_async (ext_sync),
        .o_edge  (w_sync_edge)
    );

    assign w_wrap    = (r_cnt == L_LAST);
    assign w_cnt_inc = w_wrap ? '0 : r_cnt + CNT_W'(1);
    assign w_tim     = decode_timing(int'(r_cnt), PERIOD, CLK_LOW, CLK_HIGH,
                                     WS_START, WS_END, CONV_START);

    // r_seen records a sync edge since the last wrap; an edge landing on the wrap
    // itself belongs to the frame that is ending, so the new frame starts unseen.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_cnt_inc;
        w_miss_nxt  = r_miss;
        w_seen_nxt  = r_seen;
        w_slip_nxt  = r_slip;

        case (r_state)
            ST_FREE: begin
                w_miss_nxt = '0;
                w_seen_nxt = 1'b0;
                if (sync_en) begin
                    w_state_nxt = ST_SEEK;
                end
            end

            ST_SEEK: begin
                w_miss_nxt = '0;
                w_seen_nxt = 1'b0;
                if (!sync_en) begin
                    w_state_nxt = ST_FREE;
                end else if (w_sync_edge) begin
                    w_state_nxt = ST_LOCKED;
                    w_cnt_nxt   = L_SYNC_PHASE;
                    w_seen_nxt  = !w_wrap;
                end
            end

            ST_LOCKED: begin
                if (!sync_en) begin
                    w_state_nxt = ST_FREE;
                    w_miss_nxt  = '0;
                    w_seen_nxt  = 1'b0;
                end else if (w_sync_edge) begin
                    w_miss_nxt = '0;
                    w_seen_nxt = !w_wrap;
                    if (r_cnt != L_SYNC_PREV) begin
                        w_cnt_nxt  = L_SYNC_PHASE;
                        w_slip_nxt = sat_inc(r_slip);
                    end
                end else if (w_wrap) begin
                    w_seen_nxt = 1'b0;
                    if (!r_seen) begin
                        if (r_miss == L_MISS_LAST) begin
                            w_state_nxt = ST_SEEK;
                            w_miss_nxt  = '0;
                        end else begin
                            w_miss_nxt = r_miss + MISS_W'(1);
                        end
                    end
                end
            end

            default: begin
                w_state_nxt = ST_FREE;
                w_miss_nxt  = '0;
                w_seen_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PLL_clk_100MHz) begin
        if (reset) begin
            r_state <= ST_FREE;
            r_cnt   <= '0;
            r_miss  <= '0;
            r_seen  <= 1'b0;
            r_slip  <= '0;
            r_tim   <= TIM_IDLE;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_miss  <= w_miss_nxt;
            r_seen  <= w_seen_nxt;
            r_slip  <= w_slip_nxt;
            r_tim   <= w_tim;
        end
    end

    assign clk_2mhz_utdc       = r_tim.clk;
    assign ADCs_word_sync      = r_tim.ws_n;
    assign ADCs_start_conv_out = r_tim.conv_n;
    assign frame_tick          = r_tim.tick;
    assign locked              = (r_state == ST_LOCKED);
    assign slip_count          = r_slip;
    assign frame_cnt           = r_cnt;

endmodule

// File: tb/tb_adc_timing_generator.sv
// Bench for adc_timing_generator: directed lock/slip/unlock/reset scenarios plus
// randomized traffic, all compared each cycle against a frame-arithmetic model.
module tb_adc_timing_generator;

    localparam int P          = 50;
    localparam int CLK_LOW    = 18;
    localparam int CLK_HIGH   = 44;
    localparam int WS_START   = 34;
    localparam int WS_END     = 39;
    localparam int CONV_START = 44;
    localparam int SYNC_PHASE = 0;
    localparam int MISS_MAX   = 4;

    localparam int M_FREE   = 0;
    localparam int M_SEEK   = 1;
    localparam int M_LOCKED = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       ext = 1'b0;
    logic       clk_2mhz_utdc;
    logic       ADCs_word_sync;
    logic       ADCs_start_conv_out;
    logic       frame_tick;
    logic       locked;
    logic [7:0] slip_count;
    logic [5:0] frame_cnt;

    adc_timing_generator dut (
        .PLL_clk_100MHz      (clk),
        .reset               (rst),
        .sync_en             (en),
        .ext_sync            (ext),
        .clk_2mhz_utdc       (clk_2mhz_utdc),
        .ADCs_word_sync      (ADCs_word_sync),
        .ADCs_start_conv_out (ADCs_start_conv_out),
        .frame_tick          (frame_tick),
        .locked              (locked),
        .slip_count          (slip_count),
        .frame_cnt           (frame_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: the count is (edge index - anchor) mod P; a realignment
    // just moves the anchor. Lock loss is judged by frames elapsed since the
    // frame that last carried a sync edge. Sync edges are the pin history
    // delayed by three edges.
    int       m_n = 0;
    int       m_anchor = 0;
    int       m_mode = M_FREE;
    int       m_slip = 0;
    int       m_frame = 0;
    int       m_last = 0;
    bit [3:0] m_hist = '0;
    logic     e_clk, e_ws, e_sc, e_tick, e_locked;
    logic [5:0] e_cnt;
    logic [7:0] e_slip;

    function automatic int md(input int x);
        return ((x % P) + P) % P;
    endfunction

    task automatic model_step();
        int c;
        bit e;
        bit wrap;
        bit realign;
        m_n++;
        e = m_hist[2] & ~m_hist[3];
        m_hist = {m_hist[2:0], bit'(ext)};
        if (rst) begin
            m_anchor = m_n;
            m_mode   = M_FREE;
            m_slip   = 0;
            m_hist   = '0;
            e_clk    = 1'b1;
            e_ws     = 1'b1;
            e_sc     = 1'b1;
            e_tick   = 1'b0;
        end else begin
            c       = md(m_n - 1 - m_anchor);
            e_clk   = !(c >= CLK_LOW && c < CLK_HIGH);
            e_ws    = !(c >= WS_START && c < WS_END);
            e_sc    = !(c >= CONV_START);
            wrap    = (c == P - 1);
            e_tick  = wrap;
            realign = 1'b0;
            case (m_mode)
                M_FREE: if (en) m_mode = M_SEEK;
                M_SEEK: begin
                    if (!en) m_mode = M_FREE;
                    else if (e) begin
                        realign = 1'b1;
                        m_mode  = M_LOCKED;
                        m_last  = m_frame;
                    end
                end
                default: begin
                    if (!en) m_mode = M_FREE;
                    else begin
                        if (e) begin
                            m_last = m_frame;
                            if (c != md(SYNC_PHASE - 1)) begin
                                realign = 1'b1;
                                if (m_slip < 255) m_slip++;
                            end
                        end
                        if (wrap && (m_frame - m_last) >= MISS_MAX) m_mode = M_SEEK;
                    end
                end
            endcase
            if (wrap) m_frame++;
            if (realign) m_anchor = m_n - SYNC_PHASE;
        end
        e_locked = (m_mode == M_LOCKED);
        e_cnt    = 6'(md(m_n - m_anchor));
        e_slip   = 8'(m_slip);
    endtask

    // Square-wave generator for ext_sync (period P, high for P/2, rise at phase 0).
    bit wave_on = 1'b0;
    int wave_ph = 0;

    int cyc = 0;
    int st_clk_low, st_ws_low, st_sc_low, st_ticks, st_locked;
    int last_tick = -1;
    int tick_gap = 0;

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        check("timing",
              64'({clk_2mhz_utdc, ADCs_word_sync, ADCs_start_conv_out, frame_tick, frame_cnt}),
              64'({e_clk, e_ws, e_sc, e_tick, e_cnt}));
        check("lock", 64'({locked, slip_count}), 64'({e_locked, e_slip}));
        if (!clk_2mhz_utdc) st_clk_low++;
        if (!ADCs_word_sync) st_ws_low++;
        if (!ADCs_start_conv_out) st_sc_low++;
        if (locked) st_locked++;
        if (frame_tick) begin
            if (last_tick >= 0) tick_gap = cyc - last_tick;
            last_tick = cyc;
            st_ticks++;
        end
        if (wave_on) begin
            wave_ph = (wave_ph + 1) % P;
            ext = (wave_ph < P / 2);
        end
    endtask

    task automatic clear_stats();
        st_clk_low = 0;
        st_ws_low  = 0;
        st_sc_low  = 0;
        st_ticks   = 0;
        st_locked  = 0;
    endtask

    // Delay the next ext_sync rise by d cycles (1..P/2-1), applied in the low half.
    task automatic shift_wave(input int d);
        for (int i = 0; i < 2 * P && wave_ph != P - 1; i++) tick();
        check("shift_sync", 64'(wave_ph), 64'(P - 1));
        wave_ph = wave_ph - d;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int t_rise;
        int cnt_prev;

        repeat (3) tick();
        check("rst_outs", 64'({clk_2mhz_utdc, ADCs_word_sync, ADCs_start_conv_out}), 64'(3'b111));
        check("rst_tick", 64'(frame_tick), 64'(0));
        check("rst_cnt", 64'(frame_cnt), 64'(0));
        check("rst_lock", 64'({locked, slip_count}), 64'(0));
        rst = 1'b0;
        tick();
        check("rel_cnt", 64'(frame_cnt), 64'(1));

        // Free-run: ext_sync wiggles but is ignored with sync_en low.
        repeat (37) begin ext = 1'($urandom_range(0, 1)); tick(); end
        clear_stats();
        repeat (2 * P) begin ext = 1'($urandom_range(0, 1)); tick(); end
        check("free_clk_low", 64'(st_clk_low), 64'(2 * 26));
        check("free_ws_low", 64'(st_ws_low), 64'(2 * 5));
        check("free_sc_low", 64'(st_sc_low), 64'(2 * 6));
        check("free_ticks", 64'(st_ticks), 64'(2));
        check("free_tick_gap", 64'(tick_gap), 64'(P));
        check("free_locked", 64'(st_locked), 64'(0));

        // Acquire at a random phase.
        ext = 1'b0;
        repeat (6) tick();
        en = 1'b1;
        repeat ($urandom_range(3, 70)) tick();
        ext = 1'b1;
        wave_on = 1'b1;
        wave_ph = 0;
        t_rise = cyc;
        repeat (3) tick();
        check("acq_early", 64'(locked), 64'(0));
        tick();
        check("acq_locked", 64'(locked), 64'(1));
        check("acq_cnt", 64'(frame_cnt), 64'(SYNC_PHASE));
        check("acq_slip", 64'(slip_count), 64'(0));

        // Steady in-phase sync for 1000 frames.
        clear_stats();
        repeat (1000 * P) tick();
        check("steady_slip", 64'(slip_count), 64'(0));
        check("steady_locked", 64'(st_locked), 64'(1000 * P));

        // Sync shifted by 7 cycles, then by a random amount.
        shift_wave(7);
        repeat (8 * P) tick();
        check("shift7_slip", 64'(slip_count), 64'(1));
        check("shift7_locked", 64'(locked), 64'(1));
        shift_wave($urandom_range(1, P / 2 - 1));
        repeat (6 * P) tick();
        check("shiftr_slip", 64'(slip_count), 64'(2));

        // Stop the sync after one more rise; lock drops at the 4th edgeless wrap.
        for (int i = 0; i < 2 * P && wave_ph != 0; i++) tick();
        check("stop_sync", 64'(wave_ph), 64'(0));
        t_rise = cyc;
        wave_on = 1'b0;
        repeat (10) tick();
        ext = 1'b0;
        for (int i = 0; i < 6 * P && locked; i++) tick();
        check("unlock_delay", 64'(cyc - t_rise), 64'(4 + MISS_MAX * P));
        check("unlock_tick", 64'(frame_tick), 64'(1));
        cnt_prev = frame_cnt;
        tick();
        check("unlock_running", 64'(frame_cnt), 64'((cnt_prev + 1) % P));

        // Reset pulse mid-frame at count 40.
        for (int i = 0; i < 2 * P && frame_cnt != 40; i++) tick();
        check("wait_cnt40", 64'(frame_cnt), 64'(40));
        rst = 1'b1;
        tick();
        check("mid_rst_outs", 64'({clk_2mhz_utdc, ADCs_word_sync, ADCs_start_conv_out}), 64'(3'b111));
        check("mid_rst_cnt", 64'(frame_cnt), 64'(0));
        check("mid_rst_slip", 64'(slip_count), 64'(0));
        rst = 1'b0;
        tick();
        check("mid_rel_outs", 64'({clk_2mhz_utdc, ADCs_word_sync, ADCs_start_conv_out}), 64'(3'b111));
        check("mid_rel_cnt", 64'(frame_cnt), 64'(1));

        // Randomized traffic: jittered sync, enable toggles, sparse resets.
        wave_on = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 149) == 0) en = ~en;
            if ($urandom_range(0, 79) == 0) wave_ph = $urandom_range(0, P - 1);
            if ($urandom_range(0, 399) == 0) wave_on = ~wave_on;
            if (!wave_on) ext = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 999) == 0);
            tick();
        end
        rst = 1'b0;
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
